// File: rtl/axis_deserializer.sv
// Packs NO_CHANNELS consecutive narrow AXI-Stream beats into one wide word.
// A beat with TLAST closes the word early; unused upper slots read as zero.
module axis_deserializer #(
  parameter int unsigned AXIS_WIDTH  = 32,
  parameter int unsigned NO_CHANNELS = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  output logic                               S_AXIS_TREADY,
  input  logic                               S_AXIS_TVALID,
  input  logic                               S_AXIS_TLAST,
  input  logic [AXIS_WIDTH-1:0]              S_AXIS_TDATA,
  input  logic                               M_AXIS_TREADY,
  output logic                               M_AXIS_TVALID,
  output logic                               M_AXIS_TLAST,
  output logic [AXIS_WIDTH*NO_CHANNELS-1:0]  M_AXIS_TDATA,
  output logic                               short_frame
);

  localparam int unsigned CHAN_W = $clog2(NO_CHANNELS);
  localparam int unsigned WORD_W = AXIS_WIDTH * NO_CHANNELS;
  localparam int unsigned BUF_W  = AXIS_WIDTH * (NO_CHANNELS - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NO_CHANNELS - 1);

  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              short_q, short_d;

  logic              ready_c;
  logic              beat_c;
  logic              complete_c;
  logic [WORD_W-1:0] word_c;

  // Upstream may advance whenever the output register is empty or being drained.
  assign ready_c       = !valid_q || M_AXIS_TREADY;
  assign beat_c        = S_AXIS_TVALID && ready_c;
  assign complete_c    = beat_c && ((chan_q == LAST_CHAN) || S_AXIS_TLAST);
  assign S_AXIS_TREADY = ready_c;

  assign M_AXIS_TVALID = valid_q;
  assign M_AXIS_TLAST  = last_q;
  assign M_AXIS_TDATA  = data_q;
  assign short_frame   = short_q;

  // Stored slots already sit below chan and everything above is zero, so the
  // incoming beat only has to be dropped into slot chan.
  always_comb begin
    word_c = WORD_W'(buf_q);
    for (int unsigned k = 0; k < NO_CHANNELS; k++) begin
      if (CHAN_W'(k) == chan_q) begin
        word_c[k*AXIS_WIDTH +: AXIS_WIDTH] = S_AXIS_TDATA;
      end
    end
  end

  always_comb begin
    chan_d  = chan_q;
    buf_d   = buf_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q && !M_AXIS_TREADY;
    short_d = 1'b0;

    if (complete_c) begin
      data_d  = word_c;
      last_d  = S_AXIS_TLAST;
      valid_d = 1'b1;
      short_d = S_AXIS_TLAST && (chan_q != LAST_CHAN);
      chan_d  = '0;
      buf_d   = '0;
    end else if (beat_c) begin
      for (int unsigned k = 0; k < NO_CHANNELS - 1; k++) begin
        if (CHAN_W'(k) == chan_q) begin
          buf_d[k*AXIS_WIDTH +: AXIS_WIDTH] = S_AXIS_TDATA;
        end
      end
      chan_d = chan_q + CHAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chan_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      chan_q  <= chan_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      short_q <= short_d;
    end
  end

endmodule
